// File: rtl/dmem_port_arbiter.sv
// Arbitrates one data-memory read/write port between NUM_REQ requesters.
// Round-robin or fixed priority with starvation escape; read data returns with a one-hot rvalid.
module dmem_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            mode,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rvalid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_we,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic [PTR_W-1:0]                dbg_ptr
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);

    // Handshake: req[i] (with its we/addr/wdata) is held until the cycle gnt[i] is high;
    // the access is taken at the edge ending that cycle, so a req still high afterwards
    // is a new request. For reads, rvalid[i] marks rd_data valid one cycle later.

    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] wait_cnt [NUM_REQ];

    logic             gnt_found;
    logic [PTR_W-1:0] gnt_idx;
    int               rr_idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_idx    = 0;
        if (mode) begin
            // Starved requesters take precedence, lowest index first.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_found && req[i] && (wait_cnt[i] == STARVE_MAX)) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_found && req[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                rr_idx = (int'(ptr) + k) % NUM_REQ;
                if (!gnt_found && req[rr_idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'(rr_idx);
                end
            end
        end
        if (reset) begin
            gnt_found = 1'b0;
        end
    end

    always_comb begin
        gnt       = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt_found) begin
            gnt[gnt_idx] = 1'b1;
            mem_addr     = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata    = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            mem_we       = req_we[gnt_idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr    <= '0;
            rvalid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            rvalid <= gnt & ~{NUM_REQ{mem_we}};
            if (gnt_found) begin
                ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
            end
            // Counters run in both modes so a switch to fixed priority sees true wait times.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] || !req[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != STARVE_MAX) begin
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rd_data = mem_rdata;
    assign dbg_ptr = ptr;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Table-driven bench for dmem_port_arbiter with a small registered memory model.
// Requester i presents addr = row.addr ^ (i<<6) and wdata = row.wdata ^ (i<<28).
module tb_dmem_port_arbiter;

    logic         clock;
    logic         reset;
    logic         mode;
    logic [3:0]   req;
    logic [3:0]   req_we;
    logic [35:0]  req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   gnt;
    logic [3:0]   rvalid;
    logic [31:0]  rd_data;
    logic [8:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_we;
    logic [31:0]  mem_rdata;
    logic [1:0]   dbg_ptr;

    dmem_port_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(9), .DATA_WIDTH(32), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
        .rd_data(rd_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .dbg_ptr(dbg_ptr)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory model: registered read, write at edge, initial word = 0x5A000000 + address
    logic [31:0] mem [512];
    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 32'h5A00_0000 + 32'(a);
    end
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        mode;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  e_gnt;
        logic        e_we;
        logic [8:0]  e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_rv;
        logic [31:0] e_rd;
        logic [1:0]  e_ptr;
    } vec_t;

    vec_t        tbl [31];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic m, input logic [3:0] r, input logic [3:0] w,
                         input logic [8:0] a, input logic [31:0] d);
        mode = m;
        req  = r;
        req_we = w;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*9 +: 9]   = a ^ 9'(i << 6);
            req_wdata[i*32 +: 32] = d ^ (32'(i) << 28);
        end
    endtask

    // rd_data scoreboard: expected data queued per expected rvalid, popped per observed rvalid
    task automatic check_read(input logic [3:0] e_rv, input logic [31:0] e_rd);
        if (e_rv != 4'b0) exp_q.push_back(e_rd);
        if (rvalid != 4'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_data: unexpected rvalid %b at %0t", rvalid, $time);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        //            mode req   we    addr    wdata         gnt   we    addr    wdata         rv    rd            ptr
        // round-robin, four reads held
        tbl[0]  = '{1'b0, 4'hF, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h0, 32'h0,        2'd0};
        tbl[1]  = '{1'b0, 4'hF, 4'h0, 9'h000, 32'h0,        4'h2, 1'b0, 9'h040, 32'h10000000, 4'h1, 32'h5A000000, 2'd1};
        tbl[2]  = '{1'b0, 4'hF, 4'h0, 9'h000, 32'h0,        4'h4, 1'b0, 9'h080, 32'h20000000, 4'h2, 32'h5A000040, 2'd2};
        tbl[3]  = '{1'b0, 4'hF, 4'h0, 9'h000, 32'h0,        4'h8, 1'b0, 9'h0C0, 32'h30000000, 4'h4, 32'h5A000080, 2'd3};
        tbl[4]  = '{1'b0, 4'hF, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h8, 32'h5A0000C0, 2'd0};
        // write 0xDEADBEEF to 0x005 from req 2, read back from req 1
        tbl[5]  = '{1'b0, 4'h4, 4'h4, 9'h085, 32'hFEADBEEF, 4'h4, 1'b1, 9'h005, 32'hDEADBEEF, 4'h1, 32'h5A000000, 2'd1};
        tbl[6]  = '{1'b0, 4'h2, 4'h0, 9'h045, 32'h0,        4'h2, 1'b0, 9'h005, 32'h10000000, 4'h0, 32'h0,        2'd3};
        tbl[7]  = '{1'b0, 4'h0, 4'hF, 9'h1FF, 32'hFFFFFFFF, 4'h0, 1'b0, 9'h000, 32'h00000000, 4'h2, 32'hDEADBEEF, 2'd2};
        // idle after grant to 2, then 1001 goes to 3
        tbl[8]  = '{1'b0, 4'h4, 4'h0, 9'h000, 32'h0,        4'h4, 1'b0, 9'h080, 32'h20000000, 4'h0, 32'h0,        2'd2};
        tbl[9]  = '{1'b0, 4'h0, 4'hF, 9'h1FF, 32'hFFFFFFFF, 4'h0, 1'b0, 9'h000, 32'h00000000, 4'h4, 32'h5A000080, 2'd3};
        tbl[10] = '{1'b0, 4'h0, 4'hF, 9'h1FF, 32'hFFFFFFFF, 4'h0, 1'b0, 9'h000, 32'h00000000, 4'h0, 32'h0,        2'd3};
        tbl[11] = '{1'b0, 4'h0, 4'hF, 9'h1FF, 32'hFFFFFFFF, 4'h0, 1'b0, 9'h000, 32'h00000000, 4'h0, 32'h0,        2'd3};
        tbl[12] = '{1'b0, 4'h9, 4'h0, 9'h000, 32'h0,        4'h8, 1'b0, 9'h0C0, 32'h30000000, 4'h0, 32'h0,        2'd3};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 9'h000, 32'h0,        4'h0, 1'b0, 9'h000, 32'h00000000, 4'h8, 32'h5A0000C0, 2'd0};
        // fixed priority, req 0 and 3 held: 3 wins on its 5th cycle, then again 5 later
        tbl[14] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h0, 32'h0,        2'd0};
        tbl[15] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h1, 32'h5A000000, 2'd1};
        tbl[16] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h1, 32'h5A000000, 2'd1};
        tbl[17] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h1, 32'h5A000000, 2'd1};
        tbl[18] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h8, 1'b0, 9'h0C0, 32'h30000000, 4'h1, 32'h5A000000, 2'd1};
        tbl[19] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h8, 32'h5A0000C0, 2'd0};
        tbl[20] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h1, 32'h5A000000, 2'd1};
        tbl[21] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h1, 32'h5A000000, 2'd1};
        tbl[22] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h1, 32'h5A000000, 2'd1};
        tbl[23] = '{1'b1, 4'h9, 4'h0, 9'h000, 32'h0,        4'h8, 1'b0, 9'h0C0, 32'h30000000, 4'h1, 32'h5A000000, 2'd1};
        // back to round-robin without touching ptr
        tbl[24] = '{1'b0, 4'h9, 4'h0, 9'h000, 32'h0,        4'h1, 1'b0, 9'h000, 32'h00000000, 4'h8, 32'h5A0000C0, 2'd0};
        tbl[25] = '{1'b0, 4'h9, 4'h0, 9'h000, 32'h0,        4'h8, 1'b0, 9'h0C0, 32'h30000000, 4'h1, 32'h5A000000, 2'd1};
        tbl[26] = '{1'b0, 4'h0, 4'h0, 9'h000, 32'h0,        4'h0, 1'b0, 9'h000, 32'h00000000, 4'h8, 32'h5A0000C0, 2'd0};
        // read then write back to back, then read the written word
        tbl[27] = '{1'b0, 4'h2, 4'h0, 9'h000, 32'h0,        4'h2, 1'b0, 9'h040, 32'h10000000, 4'h0, 32'h0,        2'd0};
        tbl[28] = '{1'b0, 4'h4, 4'h4, 9'h000, 32'h1,        4'h4, 1'b1, 9'h080, 32'h20000001, 4'h2, 32'h5A000040, 2'd2};
        tbl[29] = '{1'b0, 4'h4, 4'h0, 9'h000, 32'h0,        4'h4, 1'b0, 9'h080, 32'h20000000, 4'h0, 32'h0,        2'd3};
        tbl[30] = '{1'b0, 4'h0, 4'h0, 9'h000, 32'h0,        4'h0, 1'b0, 9'h000, 32'h00000000, 4'h4, 32'h20000001, 2'd3};

        // reset held with all requesting
        reset = 1'b1;
        drive(1'b0, 4'hF, 4'hF, 9'h1AB, 32'hCAFEF00D);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_ptr", 32'(dbg_ptr), 32'h0);
        reset = 1'b0;

        for (int r = 0; r < 31; r++) begin
            drive(tbl[r].mode, tbl[r].req, tbl[r].we, tbl[r].addr, tbl[r].wdata);
            #3;
            chk($sformatf("gnt[%0d]", r), 32'(gnt), 32'(tbl[r].e_gnt));
            chk($sformatf("mem_we[%0d]", r), 32'(mem_we), 32'(tbl[r].e_we));
            chk($sformatf("mem_addr[%0d]", r), 32'(mem_addr), 32'(tbl[r].e_addr));
            chk($sformatf("mem_wdata[%0d]", r), mem_wdata, tbl[r].e_wdata);
            chk($sformatf("rvalid[%0d]", r), 32'(rvalid), 32'(tbl[r].e_rv));
            chk($sformatf("ptr[%0d]", r), 32'(dbg_ptr), 32'(tbl[r].e_ptr));
            check_read(tbl[r].e_rv, tbl[r].e_rd);
            @(posedge clock); #1;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd_pending: got %0d missing rvalids expected 0", exp_q.size());
        end

        // reset mid-read: grant req 1 read, raise reset before the next edge
        drive(1'b0, 4'h2, 4'h0, 9'h000, 32'h0);
        #3;
        chk("mr_gnt", 32'(gnt), 32'h2);
        @(posedge clock); #1;
        chk("mr_rvalid_before", 32'(rvalid), 32'h2);
        #2 reset = 1'b1;
        #1;
        chk("mr_rvalid_cleared", 32'(rvalid), 32'h0);
        chk("mr_ptr_cleared", 32'(dbg_ptr), 32'h0);
        chk("mr_gnt_in_reset", 32'(gnt), 32'h0);
        chk("mr_addr_in_reset", 32'(mem_addr), 32'h0);
        @(posedge clock); #1;
        chk("mr_rvalid_held", 32'(rvalid), 32'h0);
        reset = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 9'h000, 32'h0);
        #3;
        chk("mr_gnt_idle", 32'(gnt), 32'h0);
        @(posedge clock); #1;
        chk("mr_no_reissue", 32'(rvalid), 32'h0);
        drive(1'b0, 4'hF, 4'h0, 9'h000, 32'h0);
        #3;
        chk("mr_first_gnt", 32'(gnt), 32'h1);
        @(posedge clock); #1;
        chk("mr_first_rvalid", 32'(rvalid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
